intpol2_out_sink: RTL and testbench
===================================

INTPOL2_OUT_SINK -- requirements
Module: intpol2_out_sink

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 20, Y-memory address width; DATAPATH_WIDTH, 12, I/Q sample width; CONFIG_WIDTH, 32, config word width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a transfer.
- nop_i  in  1  downstream stall; no FIFO reads while high.
- Empty_i  in  1  output-FIFO empty flag.
- sig_len_i  in  CONFIG_WIDTH  input signal length, in samples.
- ilen_i  in  ADDR_WIDTH  interpolation factor.
- data_I_i, data_Q_i  in  DATAPATH_WIDTH  FIFO read data, valid one cycle after a read.
- Read_Enable_o  out  1  FIFO read strobe.
- Write_Enable_o  out  1  Y-memory write strobe.
- addr_o  out  ADDR_WIDTH  Y-memory write address.
- data_I_o, data_Q_o  out  DATAPATH_WIDTH  Y-memory write data.
- busy_o, done_o  out  1  status flags.
- total_len_o  out  ADDR_WIDTH  latched sample count.
- checksum_o  out  32  running checksum.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-004 SHALL, in IDLE, move to LOAD on start_i; all other inputs are ignored in IDLE.
REQ-005 SHALL, in LOAD (1 cycle), latch total = sig_len_i*ilen_i - 2*ilen_i, truncated to ADDR_WIDTH, with total = 0 when sig_len_i < 2.
REQ-006 SHALL, on leaving LOAD, go to DONE if total == 0 and to RUN otherwise.
REQ-007 SHALL assert Read_Enable_o combinationally in RUN iff !Empty_i && !nop_i && reads_issued < total.
REQ-008 SHALL assert Write_Enable_o exactly one cycle after each read, with data_I_o/data_Q_o equal to data_I_i/data_Q_i in that same cycle.
REQ-009 SHALL start addr_o at 0 and increment it by 1 after each write; no wrap-around occurs within a transfer.
REQ-010 SHALL enter DONE in the cycle after the final write (writes == total).
REQ-011 SHALL hold done_o high for exactly one cycle in DONE, then return to IDLE.
REQ-012 SHALL hold busy_o high in LOAD and RUN only.
REQ-013 SHALL ignore start_i while busy_o is high; in the DONE cycle it SHALL also be ignored.
REQ-014 SHALL allow nop_i to stall reads at any cycle; a write already pending from the previous cycle still completes.
REQ-015 SHALL hold addr_o at its final value after DONE and reset it to 0 on the next LOAD.

Reset
REQ-016 SHALL, while rst is high (asynchronous), force state = IDLE and clear all outputs, counters, total_len_o and checksum_o to 0.
REQ-017 SHALL, on reset mid-RUN, abandon the transfer: no done_o pulse, and the pending write is dropped.

Configuration
REQ-018 SHALL, with INTPOL2_SINK_CHECKSUM_EN defined, add the sign-extended data_I_o + data_Q_o to checksum_o on each write, modulo 2^32, and clear checksum_o in LOAD.
REQ-019 SHALL, without INTPOL2_SINK_CHECKSUM_EN, tie checksum_o to 0 and synthesise no accumulator.

Structure
REQ-020 SHALL take the state encoding, default widths and the checksum width constant from shared package intpol2_pkg.
REQ-021 SHALL place the LOAD-stage length arithmetic in sub-module intpol2_len_calc (registered multiply-subtract with the sig_len < 2 clamp).

Verification
REQ-022 Case: sig_len=10, ilen=10, FIFO never empty, start pulse -> 80 writes at addr 0..79, one per cycle; done_o pulses exactly 1 cycle after the last write; total_len_o = 80.
REQ-023 Case: same setup, Empty_i high for 5 cycles after the 20th read -> no read/write gap beyond those 5 cycles; addr sequence contiguous; still 80 writes.
REQ-024 Case: nop_i high for 1000 cycles mid-RUN -> Read_Enable_o stays 0 throughout; at most 1 trailing write; resumes at the next address.
REQ-025 Case: sig_len=2, ilen=10, start -> no reads or writes; done_o pulses 2 cycles after start_i.
REQ-026 Case: rst pulsed at write 40 of 80, then new start -> no done_o for the aborted run; new run writes from addr 0.
REQ-027 Case: with INTPOL2_SINK_CHECKSUM_EN, samples I=0x001, Q=0xFFF repeated 4 times -> checksum_o = 0; I=0x7FF, Q=0x7FF once -> checksum_o = 0x00000FFE.

Source files
------------

// File: rtl/intpol2_pkg.sv
// Shared definitions for the interpolator output sink: FSM encoding,
// default datapath widths and the checksum width.
package intpol2_pkg;

  localparam int unsigned ADDR_WIDTH_DEF     = 20;
  localparam int unsigned DATAPATH_WIDTH_DEF = 12;
  localparam int unsigned CONFIG_WIDTH_DEF   = 32;
  localparam int unsigned CHECKSUM_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sink_state_e;

endpackage

// File: rtl/intpol2_len_calc.sv
// Transfer length calculation: total = sig_len*ilen - 2*ilen, truncated to
// ADDR_WIDTH, forced to 0 for signals shorter than two samples.
// total_c is the combinational value used for the LOAD branch decision;
// total_o is the registered copy latched while load_i is high.
module intpol2_len_calc
  import intpol2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned CONFIG_WIDTH = CONFIG_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [CONFIG_WIDTH-1:0] sig_len_i,
  input  logic [ADDR_WIDTH-1:0]   ilen_i,
  output logic [ADDR_WIDTH-1:0]   total_c,
  output logic [ADDR_WIDTH-1:0]   total_o
);

  logic                  short_sig;
  logic [ADDR_WIDTH-1:0] sig_m2;

  // (sig_len-2)*ilen equals sig_len*ilen - 2*ilen modulo 2^ADDR_WIDTH
  always_comb begin
    short_sig = (sig_len_i < CONFIG_WIDTH'(2));
    sig_m2    = ADDR_WIDTH'(sig_len_i - CONFIG_WIDTH'(2));
    total_c   = short_sig ? '0 : ADDR_WIDTH'(sig_m2 * ilen_i);
  end

  // Latch the length for the rest of the transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_o <= '0;
    end else if (load_i) begin
      total_o <= total_c;
    end
  end

endmodule

// File: rtl/intpol2_out_sink.sv
// Interpolator output sink: drains the output FIFO into Y-memory.
// Reads are issued while the FIFO has data and downstream is not stalled;
// each read becomes a Y-memory write one cycle later at an incrementing
// address. Optional running checksum enabled by INTPOL2_SINK_CHECKSUM_EN.
module intpol2_out_sink
  import intpol2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int unsigned CONFIG_WIDTH   = CONFIG_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      nop_i,
  input  logic                      Empty_i,
  input  logic [CONFIG_WIDTH-1:0]   sig_len_i,
  input  logic [ADDR_WIDTH-1:0]     ilen_i,
  input  logic [DATAPATH_WIDTH-1:0] data_I_i,
  input  logic [DATAPATH_WIDTH-1:0] data_Q_i,
  output logic                      Read_Enable_o,
  output logic                      Write_Enable_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [DATAPATH_WIDTH-1:0] data_I_o,
  output logic [DATAPATH_WIDTH-1:0] data_Q_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [ADDR_WIDTH-1:0]     total_len_o,
  output logic [CHECKSUM_WIDTH-1:0] checksum_o
);

  sink_state_e           state_q;
  sink_state_e           state_d;
  logic [ADDR_WIDTH-1:0] total_c;
  logic [ADDR_WIDTH-1:0] reads_q;
  logic                  last_wr_c;

  intpol2_len_calc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CONFIG_WIDTH (CONFIG_WIDTH)
  ) u_len_calc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (state_q == ST_LOAD),
    .sig_len_i (sig_len_i),
    .ilen_i    (ilen_i),
    .total_c   (total_c),
    .total_o   (total_len_o)
  );

  // Current write is the last one of the transfer
  assign last_wr_c = Write_Enable_o && ((addr_o + ADDR_WIDTH'(1)) == total_len_o);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LOAD;
      ST_LOAD: state_d = (total_c == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_wr_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs: FIFO read strobe and write data pass-through
  always_comb begin
    Read_Enable_o = 1'b0;
    data_I_o      = '0;
    data_Q_o      = '0;
    if ((state_q == ST_RUN) && !Empty_i && !nop_i && (reads_q < total_len_o)) begin
      Read_Enable_o = 1'b1;
    end
    if (Write_Enable_o) begin
      data_I_o = data_I_i;
      data_Q_o = data_Q_i;
    end
  end

  // Write strobe, address/read counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Write_Enable_o <= 1'b0;
      addr_o         <= '0;
      reads_q        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      Write_Enable_o <= Read_Enable_o;
      busy_o         <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_o         <= (state_d == ST_DONE);
      if (state_q == ST_LOAD) begin
        addr_o  <= '0;
        reads_q <= '0;
      end else begin
        if (Read_Enable_o) reads_q <= reads_q + ADDR_WIDTH'(1);
        if (Write_Enable_o) addr_o <= addr_o + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef INTPOL2_SINK_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] checksum_q;

  // Running sum of sign-extended I+Q over every write, cleared per transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (state_q == ST_LOAD) begin
      checksum_q <= '0;
    end else if (Write_Enable_o) begin
      checksum_q <= checksum_q
                  + CHECKSUM_WIDTH'(signed'(data_I_o))
                  + CHECKSUM_WIDTH'(signed'(data_Q_o));
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_intpol2_out_sink.sv
// Bench for intpol2_out_sink: table of transfers, FIFO model feeding data
// one cycle after each read, scoreboard of expected writes.
`timescale 1ns/1ps
module tb_intpol2_out_sink;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 12;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, nop_i, Empty_i;
  logic [CW-1:0] sig_len_i;
  logic [AW-1:0] ilen_i;
  logic [DW-1:0] data_I_i, data_Q_i;
  logic          Read_Enable_o, Write_Enable_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_I_o, data_Q_o;
  logic          busy_o, done_o;
  logic [AW-1:0] total_len_o;
  logic [31:0]   checksum_o;

  always #5 clk = ~clk;

  intpol2_out_sink #(
    .ADDR_WIDTH(AW), .DATAPATH_WIDTH(DW), .CONFIG_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .nop_i(nop_i), .Empty_i(Empty_i),
    .sig_len_i(sig_len_i), .ilen_i(ilen_i), .data_I_i(data_I_i), .data_Q_i(data_Q_i),
    .Read_Enable_o(Read_Enable_o), .Write_Enable_o(Write_Enable_o), .addr_o(addr_o),
    .data_I_o(data_I_o), .data_Q_o(data_Q_o), .busy_o(busy_o), .done_o(done_o),
    .total_len_o(total_len_o), .checksum_o(checksum_o)
  );

  // kind: 0 no stall, 1 Empty_i window, 2 nop_i window
  // mode: 0 random data, 1 I=001/Q=FFF, 2 I=7FF/Q=7FF
  typedef struct {
    logic [CW-1:0] sig_len;
    logic [AW-1:0] ilen;
    int            exp_total;
    int            kind;
    int            stall_at;
    int            stall_len;
    int            exp_gap;
    int            mode;
    int            rst_at;
    bit            poke;
  } vec_t;

  typedef struct {
    int            addr;
    logic [DW-1:0] di;
    logic [DW-1:0] dq;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_re"},    64'(Read_Enable_o), 0);
    chk({tag, "_we"},    64'(Write_Enable_o), 0);
    chk({tag, "_addr"},  64'(addr_o), 0);
    chk({tag, "_busy"},  64'(busy_o), 0);
    chk({tag, "_done"},  64'(done_o), 0);
    chk({tag, "_total"}, 64'(total_len_o), 0);
    chk({tag, "_ck"},    64'(checksum_o), 0);
    chk({tag, "_di"},    64'(data_I_o), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int    cyc = 1;
    int    reads = 0, writes = 0, last_wr = 0, done_cyc = 0, max_gap = 0;
    int    stall_left = 0, win_leak = 0, win_wr = 0, push_idx = 0, busy_bad = 0, quiet_bad = 0;
    bit    prev_rd = 0, stalled = 0, done_seen = 0, poked_mid = 0, poked_done = 0, in_win;
    bit    busy_at_done = 0;
    logic [AW-1:0] tot_seen = '0, addr_seen = '0;
    logic [31:0]   ck_seen = '0, ck_exp;
    beat_t b;

    sb.delete();
    exp_ck    = '0;
    sig_len_i = v.sig_len;
    ilen_i    = v.ilen;
    @(negedge clk);
    start_i = 1'b1; nop_i = 1'b0; Empty_i = 1'b0;
    #1 chk("idle_re", 64'(Read_Enable_o), 0);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("load_busy", 64'(busy_o), 1);
    chk("load_done", 64'(done_o), 0);

    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      if (v.poke && !poked_mid && writes == 10) begin start_i = 1'b1; poked_mid = 1; end
      if (v.poke && !poked_done && v.exp_total > 0 && writes == v.exp_total) begin
        start_i = 1'b1; poked_done = 1;
      end
      in_win  = (stall_left > 0);
      Empty_i = (v.kind == 1) && in_win;
      nop_i   = (v.kind == 2) && in_win;
      if (in_win) stall_left--;
      if (prev_rd) begin
        case (v.mode)
          1:       begin b.di = 12'h001; b.dq = 12'hFFF; end
          2:       begin b.di = 12'h7FF; b.dq = 12'h7FF; end
          default: begin b.di = DW'($urandom); b.dq = DW'($urandom); end
        endcase
        b.addr = push_idx++;
        sb.push_back(b);
        data_I_i = b.di; data_Q_i = b.dq;
      end else begin
        data_I_i = DW'($urandom); data_Q_i = DW'($urandom);
      end

      if (v.rst_at > 0 && writes == v.rst_at) begin
        rst = 1'b1;
        #1 chk_zero_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          #1 if (done_o || Write_Enable_o || busy_o) quiet_bad++;
        end
        chk("rst_quiet", 64'(quiet_bad), 0);
        return;
      end

      #1;
      if (Write_Enable_o) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          b = sb.pop_front();
          chk("wr_addr", 64'(addr_o), 64'(b.addr));
          chk("wr_data", {40'd0, data_I_o, data_Q_o}, {40'd0, b.di, b.dq});
`ifdef INTPOL2_SINK_CHECKSUM_EN
          exp_ck = exp_ck + {{(32-DW){b.di[DW-1]}}, b.di} + {{(32-DW){b.dq[DW-1]}}, b.dq};
`endif
        end
        if (writes > 0 && (cyc - last_wr) > max_gap) max_gap = cyc - last_wr;
        last_wr = cyc;
        writes++;
        if (in_win && v.kind == 2) win_wr++;
      end
      if (Read_Enable_o) begin
        reads++;
        if (in_win && v.kind == 2) win_leak++;
      end
      prev_rd = Read_Enable_o;
      if (done_o) begin
        done_seen = 1; done_cyc = cyc; tot_seen = total_len_o;
        addr_seen = addr_o; busy_at_done = busy_o; ck_seen = checksum_o;
        break;
      end
      if (!busy_o) busy_bad++;
      if (!stalled && v.kind != 0 && reads == v.stall_at) begin
        stalled = 1; stall_left = v.stall_len;
      end
    end

    chk("done_seen", 64'(done_seen), 1);
    if (!done_seen) return;
    chk("reads", 64'(reads), 64'(v.exp_total));
    chk("writes", 64'(writes), 64'(v.exp_total));
    chk("total_len", 64'(tot_seen), 64'(v.exp_total));
    if (v.exp_total > 0) chk("done_after_last_wr", 64'(done_cyc - last_wr), 1);
    else                 chk("done_after_start", 64'(done_cyc), 2);
    chk("busy_in_run", 64'(busy_bad), 0);
    chk("busy_at_done", 64'(busy_at_done), 0);
    chk("final_addr", 64'(addr_seen), 64'(v.exp_total));
    chk("sb_drained", 64'(sb.size()), 0);
    if (v.exp_total > 1) chk("max_wr_gap", 64'(max_gap), 64'(v.exp_gap));
    if (v.kind == 2) begin
      chk("nop_re_leak", 64'(win_leak), 0);
      chk("nop_trailing_wr", 64'(win_wr <= 1), 1);
    end
`ifdef INTPOL2_SINK_CHECKSUM_EN
    ck_exp = (v.mode == 2) ? 32'h0000_0FFE : ((v.mode == 1) ? 32'h0 : exp_ck);
`else
    ck_exp = 32'h0;
`endif
    chk("checksum", 64'(ck_seen), 64'(ck_exp));

    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("post_done", 64'(done_o), 0);
    chk("post_busy", 64'(busy_o), 0);
    chk("post_addr_hold", 64'(addr_o), 64'(v.exp_total));
    chk("post_total_hold", 64'(total_len_o), 64'(v.exp_total));
    @(negedge clk);
    #1 chk("post_idle_busy", 64'(busy_o), 0);
  endtask

  initial begin
    vec_t vecs[14];
    rst = 1'b1; start_i = 1'b0; nop_i = 1'b0; Empty_i = 1'b0;
    sig_len_i = '0; ilen_i = '0; data_I_i = '0; data_Q_i = '0;
    #2 chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("idle_busy", 64'(busy_o), 0);

    //          sig_len        ilen         tot kind at  len   gap  mode rst poke
    vecs[0]  = '{32'd10,        20'd10,      80, 0,  0,  0,    1,   0,   0,  1'b1};
    vecs[1]  = '{32'd10,        20'd10,      80, 1,  20, 5,    6,   0,   0,  1'b0};
    vecs[2]  = '{32'd10,        20'd10,      80, 2,  30, 1000, 1001,0,   0,  1'b0};
    vecs[3]  = '{32'd2,         20'd10,      0,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[4]  = '{32'd1,         20'd5,       0,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[5]  = '{32'd0,         20'd3,       0,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[6]  = '{32'd3,         20'd7,       7,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[7]  = '{32'd5,         20'd1,       3,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[8]  = '{32'h0010_0002, 20'd1,       0,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[9]  = '{32'd4,         20'h8_0001,  2,  0,  0,  0,    1,   0,   0,  1'b0};
    vecs[10] = '{32'd10,        20'd10,      80, 0,  0,  0,    1,   0,   40, 1'b0};
    vecs[11] = '{32'd10,        20'd10,      80, 0,  0,  0,    1,   0,   0,  1'b0};
    vecs[12] = '{32'd3,         20'd4,       4,  0,  0,  0,    1,   1,   0,  1'b0};
    vecs[13] = '{32'd3,         20'd1,       1,  0,  0,  0,    1,   2,   0,  1'b0};

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
